// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/collect slice.
//   WIDTH/TAG_W : default operand and tag widths
//   OP_ADD/SUB  : ALU opcode encoding (1 = a+b, 0 = a-b)
//   result_t    : one result FIFO entry {result, tag} at default widths
package alu_pkg;

   localparam int   WIDTH  = 8;
   localparam int   TAG_W  = 2;
   localparam logic OP_ADD = 1'b1;
   localparam logic OP_SUB = 1'b0;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [TAG_W-1:0] tag;
   } result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous result FIFO, DEPTH entries of type T.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push_i     : write din_i at the tail
//   din_i      : entry to write
//   pop_i      : drop the head entry (caller guarantees non-empty)
//   count_o    : occupancy, 0..DEPTH
//   head_o     : head entry, valid while count_o != 0
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter type T     = result_t,
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  T                         din_i,
   input  logic                     pop_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output T                         head_o
);

   localparam int PW = $clog2(DEPTH);

   T                mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PW:0]     count_q;

   // Storage needs no reset: nothing is read until count_q says it was written.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   // DEPTH is a power of two, so the pointers wrap on plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/collect stage around a registered 1-cycle ALU.
//   in_*        : request channel (valid/ready), operands, op, tag
//   alu_a/b/op  : combinational copy of the request operands to the ALU
//   alu_out     : ALU result, valid the cycle after issue
//   out_*       : result channel (valid/ready), head result and tag
//   issued_cnt  : wrapping count of accepted requests
// A request is accepted only when its result already owns a FIFO slot
// (credit = FIFO occupancy + op in the ALU), so the FIFO cannot overflow.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int DEPTH = 4,
   parameter int TAG_W = alu_pkg::TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_op,
   input  logic [WIDTH-1:0] alu_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic [15:0]      issued_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic             pipe_v_q;
   logic [TAG_W-1:0] pipe_tag_q;
   logic [15:0]      issued_cnt_q;
   logic             rdy_en_q;
   logic [CW-1:0]    fifo_cnt;
   logic [CW-1:0]    outstanding;
   logic             fire, pop;
   entry_t           push_ent, head_ent;

   assign alu_a  = in_a;
   assign alu_b  = in_b;
   assign alu_op = in_op;

   // Ops already holding a credit: stored results plus the one in the ALU.
   // This never exceeds DEPTH, so it fits in CW bits.
   assign outstanding = fifo_cnt + CW'(pipe_v_q);
   // rdy_en_q keeps in_ready low through reset and sets on the first edge after it.
   assign in_ready    = rdy_en_q && (outstanding < CW'(DEPTH));
   assign fire        = in_valid && in_ready;
   assign out_valid   = (fifo_cnt != '0);
   assign pop         = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q     <= 1'b0;
         pipe_v_q     <= 1'b0;
         pipe_tag_q   <= '0;
         issued_cnt_q <= '0;
      end else begin
         rdy_en_q     <= 1'b1;
         pipe_v_q     <= fire;
         pipe_tag_q   <= in_tag;
         issued_cnt_q <= issued_cnt_q + 16'(fire);
      end
   end

   // alu_out is only captured while pipe_v_q marks a live op.
   assign push_ent.result = alu_out;
   assign push_ent.tag    = pipe_tag_q;

   alu_result_fifo #(
      .T     (entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (pipe_v_q),
      .din_i   (push_ent),
      .pop_i   (pop),
      .count_o (fifo_cnt),
      .head_o  (head_ent)
   );

   assign out_result = head_ent.result;
   assign out_tag    = head_ent.tag;
   assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b0;
   logic [7:0]  in_a = '0, in_b = '0;
   logic [1:0]  in_tag = '0;
   logic        in_ready, out_valid, alu_op;
   logic [7:0]  alu_a, alu_b, alu_out, out_result;
   logic [1:0]  out_tag;
   logic [15:0] issued_cnt;

   always #5 clk = ~clk;

   // Registered ALU, no reset, 1-cycle latency.
   always @(posedge clk) alu_out <= alu_op ? alu_a + alu_b : alu_a - alu_b;

   alu_issue_ctrl #(.WIDTH(8), .DEPTH(DEPTH), .TAG_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_tag(in_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .issued_cnt(issued_cnt)
   );

   int n_chk = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: every accepted op is an entry that becomes visible 2 cycles later
   // and leaves in order; accepted-but-not-consumed entries use up the credits.
   typedef struct { int res; int tag; int vis; } exp_t;
   exp_t q[$];
   int   cyc = 0;
   int   exp_cnt = 0;
   bit   rdy_en = 0;
   int   got_res[$];
   int   got_tag[$];

   always @(negedge clk) begin : cmp
      bit   er, ev;
      exp_t e;
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_issued_cnt", issued_cnt, 0);
         q.delete();
         exp_cnt = 0;
         rdy_en  = 0;
      end else begin
         er = rdy_en && (q.size() < DEPTH);
         ev = (q.size() > 0) && (q[0].vis <= cyc);
         chk("in_ready", in_ready, er);
         chk("out_valid", out_valid, ev);
         chk("issued_cnt", issued_cnt, exp_cnt);
         if (ev) begin
            chk("out_result", out_result, q[0].res);
            chk("out_tag", out_tag, q[0].tag);
            if (out_ready) begin
               got_res.push_back(int'(out_result));
               got_tag.push_back(int'(out_tag));
               void'(q.pop_front());
            end
         end
         if (in_valid && er) begin
            e.res = in_op ? (int'(in_a) + int'(in_b)) % 256
                          : (int'(in_a) - int'(in_b) + 256) % 256;
            e.tag = int'(in_tag);
            e.vis = cyc + 2;
            q.push_back(e);
            exp_cnt = (exp_cnt + 1) % 65536;
         end
         rdy_en = 1;
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_got(input int n, input string nm);
      int k;
      k = 0;
      while (got_res.size() < n && k < 20) begin
         tick();
         k++;
      end
      chk(nm, got_res.size() >= n, 1);
   endtask

   initial begin
      int acc;
      // 1: reset held with a pending request
      in_valid  = 1'b1;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (3) tick();
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);

      // 2: single op, 200+100 -> 44, latency exactly 2
      tick();
      in_valid = 1'b1; in_a = 8'd200; in_b = 8'd100; in_op = 1'b1; in_tag = 2'd2;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat1_out_valid", out_valid, 0);
      tick();
      @(negedge clk);
      chk("lat2_out_valid", out_valid, 1);
      chk("single_result", out_result, 44);
      chk("single_tag", out_tag, 2);
      tick();
      tick();

      // 3: ten back-to-back adds a=b=i
      got_res.delete(); got_tag.delete();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_a = 8'(i); in_b = 8'(i); in_op = 1'b1; in_tag = 2'(i);
         @(negedge clk);
         chk("stream_ready", in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      wait_got(10, "stream_timeout");
      for (int i = 0; i < 10 && i < got_res.size(); i++) begin
         chk("stream_result", got_res[i], 2 * i);
         chk("stream_tag", got_tag[i], i % 4);
      end
      chk("stream_issued", issued_cnt, 11);

      // 4: back-pressure, exactly DEPTH accepted then drain
      got_res.delete(); got_tag.delete();
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_a = 8'(20 + acc); in_b = 8'(20 + acc); in_op = 1'b1; in_tag = 2'(acc);
         @(negedge clk);
         if (in_ready) acc++;
         tick();
      end
      chk("bp_accepted", acc, DEPTH);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_before_pop", in_ready, 0);
      tick();
      @(negedge clk);
      chk("bp_ready_after_pop", in_ready, 1);
      wait_got(4, "bp_timeout");
      tick();
      chk("bp_count", got_res.size(), 4);
      for (int i = 0; i < 4 && i < got_res.size(); i++)
         chk("bp_result", got_res[i], 40 + 2 * i);

      // 5: subtract wrap, then push/pop overlap at count 2
      got_res.delete(); got_tag.delete();
      in_valid = 1'b1; in_a = 8'd3; in_b = 8'd5; in_op = 1'b0; in_tag = 2'd1;
      tick();
      in_valid = 1'b0;
      wait_got(1, "sub_timeout");
      if (got_res.size() > 0) chk("sub_wrap", got_res[0], 254);
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_a = 8'(i); in_b = 8'd1; in_op = 1'b1; tick();
      end
      in_valid = 1'b0;
      repeat (2) tick();
      out_ready = 1'b1;
      in_valid  = 1'b1; in_a = 8'd9; in_b = 8'd9;
      repeat (3) tick();
      in_valid = 1'b0;
      repeat (5) tick();

      // 6: reset with one op in the ALU and three in the FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_a = 8'(50 + i); in_b = 8'd1; in_op = 1'b1; tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) tick();
      got_res.delete(); got_tag.delete();
      in_valid = 1'b1; in_a = 8'd7; in_b = 8'd9; in_op = 1'b1; in_tag = 2'd3;
      tick();
      in_valid = 1'b0;
      wait_got(1, "midrst_timeout");
      tick();
      chk("midrst_count", got_res.size(), 1);
      if (got_res.size() > 0) chk("midrst_result", got_res[0], 16);

      // Randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         in_op     = 1'($urandom);
         in_tag    = 2'($urandom);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick();
      chk("final_drained", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
